// File: rtl/l1_repl_pkg.sv
// Shared definitions for the L1 replacement manager: policy selectors,
// init/ready FSM encoding and the per-set state width helper.
package l1_repl_pkg;

    localparam int REPL_BITPLRU  = 0;
    localparam int REPL_TREEPLRU = 1;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } repl_fsm_t;

    // Bit-PLRU keeps one MRU bit per way; tree-PLRU keeps one bit per internal node.
    function automatic int state_width(input int way_num, input int mode);
        return (mode == REPL_TREEPLRU) ? way_num - 1 : way_num;
    endfunction

endpackage

// File: rtl/l1_repl_sel.sv
// Combinational way selection (hit / free way / PLRU victim) and next
// replacement state for one set, for either bit-PLRU or tree-PLRU.
module l1_repl_sel
    import l1_repl_pkg::*;
#(
    parameter int WAY_NUM = 4,
    parameter int MODE    = REPL_BITPLRU
) (
    input  logic [state_width(WAY_NUM, MODE)-1:0] state_cur,
    input  logic [WAY_NUM-1:0]                    hit_vect,
    input  logic [WAY_NUM-1:0]                    val_vect,
    input  logic [WAY_NUM-1:0]                    lock_vect,
    output logic                                  hit,
    output logic                                  evict,
    output logic                                  fail,
    output logic [WAY_NUM-1:0]                    way_vect,
    output logic [state_width(WAY_NUM, MODE)-1:0] state_nxt
);

    logic [WAY_NUM-1:0] alloc_ok;
    logic [WAY_NUM-1:0] free_vect;
    logic [WAY_NUM-1:0] victim_vect;

    function automatic logic [WAY_NUM-1:0] lowest_one(input logic [WAY_NUM-1:0] v);
        return v & (~v + WAY_NUM'(1));
    endfunction

    assign alloc_ok  = ~lock_vect;
    assign free_vect = lowest_one(~val_vect & alloc_ok);

    always_comb begin
        hit      = |hit_vect;
        evict    = 1'b0;
        fail     = 1'b0;
        way_vect = '0;
        if (hit) begin
            way_vect = lowest_one(hit_vect);
        end else if (alloc_ok == '0) begin
            fail = 1'b1;
        end else if (free_vect != '0) begin
            way_vect = free_vect;
        end else begin
            way_vect = victim_vect;
            evict    = 1'b1;
        end
    end

    generate
        if (MODE == REPL_TREEPLRU) begin : g_tree
            localparam int SW = WAY_NUM - 1;
            localparam int LW = $clog2(WAY_NUM);

            logic [SW-1:0]      node_bits;
            logic [WAY_NUM-1:0] avail;
            logic [SW-1:0]      node_mask;

            // Walk from the root, then slide right (wrapping) past locked ways.
            always_comb begin
                int  node;
                int  pick;
                int  cand;
                logic found;
                node        = 0;
                node_bits   = '0;
                avail       = '0;
                cand        = 0;
                for (int l = 0; l < LW; l++) begin
                    node_bits = state_cur >> node;
                    node      = 2 * node + 1 + int'(node_bits[0]);
                end
                pick        = node - (WAY_NUM - 1);
                victim_vect = '0;
                found       = 1'b0;
                for (int k = 0; k < WAY_NUM; k++) begin
                    cand  = (pick + k) % WAY_NUM;
                    avail = alloc_ok >> cand;
                    if (!found && avail[0]) begin
                        victim_vect = WAY_NUM'(1) << cand;
                        found       = 1'b1;
                    end
                end
            end

            always_comb begin
                int   node;
                int   way_idx;
                logic dir;
                way_idx = 0;
                for (int i = 0; i < WAY_NUM; i++) begin
                    if (way_vect[i]) begin
                        way_idx = i;
                    end
                end
                state_nxt = state_cur;
                node      = 0;
                node_mask = '0;
                for (int l = 0; l < LW; l++) begin
                    dir       = ((way_idx >> (LW - 1 - l)) & 1) != 0;
                    node_mask = SW'(1) << node;
                    state_nxt = dir ? (state_nxt & ~node_mask) : (state_nxt | node_mask);
                    node      = 2 * node + 1 + int'(dir);
                end
            end
        end else begin : g_bit
            logic [WAY_NUM-1:0] used;

            always_comb begin
                victim_vect = lowest_one(~state_cur & alloc_ok);
                if (victim_vect == '0) begin
                    victim_vect = lowest_one(alloc_ok);
                end
            end

            // Once every MRU bit would be set, restart history with only the touched way.
            always_comb begin
                used      = state_cur | way_vect;
                state_nxt = (&used) ? way_vect : used;
            end
        end
    endgenerate

endmodule

// File: rtl/sram_dp.sv
// Simple dual-port state SRAM: port A synchronous read, port B write.
// A read and a write to the same address in one cycle return the old word.
module sram_dp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     a_en,
    input  logic [$clog2(DEPTH)-1:0] a_addr,
    output logic [WIDTH-1:0]         a_rdata,
    input  logic                     b_we,
    input  logic [$clog2(DEPTH)-1:0] b_addr,
    input  logic [WIDTH-1:0]         b_wdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_en) begin
            a_rdata <= mem[a_addr];
        end
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

endmodule

// File: rtl/l1_repl_mgr.sv
// Parametrised L1 replacement manager with per-set PLRU state in a dual-port SRAM.
// Optional way locking is built when L1_REPL_LOCK_EN is defined.
module l1_repl_mgr
    import l1_repl_pkg::*;
#(
    parameter int WAY_NUM   = 4,
    parameter int SET_NUM   = 64,
    parameter int IDX_WIDTH = $clog2(SET_NUM),
    parameter int MODE      = REPL_BITPLRU
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [IDX_WIDTH-1:0] idx,
    input  logic                 inv_req,
    output logic                 ready,
    input  logic [WAY_NUM-1:0]   ld_val_vect,
    input  logic [WAY_NUM-1:0]   tag_cmp_vect,
    output logic                 hit,
    output logic                 evict_val,
    output logic [WAY_NUM-1:0]   way_vect
`ifdef L1_REPL_LOCK_EN
    ,
    input  logic [WAY_NUM-1:0]   lock_vect,
    output logic                 alloc_fail
`endif
);

    localparam int SW = state_width(WAY_NUM, MODE);

    repl_fsm_t            fsm;
    repl_fsm_t            fsm_nxt;
    logic [IDX_WIDTH-1:0] sweep_addr;
    logic [IDX_WIDTH-1:0] sweep_nxt;

    logic                 req_r;
    logic [IDX_WIDTH-1:0] idx_r;
    logic                 fwd_val;
    logic [SW-1:0]        fwd_state;

    logic                 rd_en;
    logic                 upd_we;
    logic                 mem_we;
    logic [IDX_WIDTH-1:0] mem_addr;
    logic [SW-1:0]        mem_wdata;
    logic [SW-1:0]        rd_state;
    logic [SW-1:0]        cur_state;
    logic [SW-1:0]        upd_state;

    logic [WAY_NUM-1:0]   lock_int;
    logic [WAY_NUM-1:0]   sel_way;
    logic                 sel_hit;
    logic                 sel_evict;
    logic                 sel_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= INIT;
            sweep_addr <= '0;
        end else begin
            fsm        <= fsm_nxt;
            sweep_addr <= sweep_nxt;
        end
    end

    always_comb begin
        fsm_nxt   = fsm;
        sweep_nxt = sweep_addr;
        case (fsm)
            INIT: begin
                if (inv_req) begin
                    sweep_nxt = '0;
                end else if (sweep_addr == IDX_WIDTH'(SET_NUM - 1)) begin
                    fsm_nxt   = READY;
                    sweep_nxt = '0;
                end else begin
                    sweep_nxt = sweep_addr + IDX_WIDTH'(1);
                end
            end
            READY: begin
                if (inv_req) begin
                    fsm_nxt   = INIT;
                    sweep_nxt = '0;
                end
            end
            default: begin
                fsm_nxt   = INIT;
                sweep_nxt = '0;
            end
        endcase
    end

    assign ready = (fsm == READY);
    assign rd_en = req & ready;

    // Updates are discarded while sweeping, on an invalidate, or when nothing was allocatable.
    assign upd_we    = req_r & ~inv_req & (fsm == READY) & ~sel_fail;
    assign mem_we    = (fsm == INIT) | upd_we;
    assign mem_addr  = (fsm == INIT) ? sweep_addr : idx_r;
    assign mem_wdata = (fsm == INIT) ? '0 : upd_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_r     <= 1'b0;
            idx_r     <= '0;
            fwd_val   <= 1'b0;
            fwd_state <= '0;
        end else begin
            req_r     <= rd_en;
            if (rd_en) begin
                idx_r <= idx;
            end
            fwd_val   <= rd_en & upd_we & (idx == idx_r);
            fwd_state <= upd_state;
        end
    end

    // The SRAM read of a back-to-back same-set request misses this cycle's write.
    assign cur_state = fwd_val ? fwd_state : rd_state;

    sram_dp #(
        .WIDTH (SW),
        .DEPTH (SET_NUM)
    ) u_state_ram (
        .clk     (clk),
        .a_en    (rd_en),
        .a_addr  (idx),
        .a_rdata (rd_state),
        .b_we    (mem_we),
        .b_addr  (mem_addr),
        .b_wdata (mem_wdata)
    );

`ifdef L1_REPL_LOCK_EN
    assign lock_int   = lock_vect;
    assign alloc_fail = req_r & sel_fail;
`else
    assign lock_int   = '0;
`endif

    l1_repl_sel #(
        .WAY_NUM (WAY_NUM),
        .MODE    (MODE)
    ) u_sel (
        .state_cur (cur_state),
        .hit_vect  (ld_val_vect & tag_cmp_vect),
        .val_vect  (ld_val_vect),
        .lock_vect (lock_int),
        .hit       (sel_hit),
        .evict     (sel_evict),
        .fail      (sel_fail),
        .way_vect  (sel_way),
        .state_nxt (upd_state)
    );

    assign hit       = req_r & sel_hit;
    assign evict_val = req_r & sel_evict;
    assign way_vect  = req_r ? sel_way : '0;

endmodule

// File: tb/tb_l1_repl_mgr.sv
// Bench for l1_repl_mgr: bit-PLRU and tree-PLRU instances share one stimulus
// stream and are checked against a per-set reference model of both policies.
module tb_l1_repl_mgr;

    localparam int W  = 4;
    localparam int S  = 64;
    localparam int IW = 6;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [IW-1:0] idx = '0;
    logic          inv_req = 1'b0;
    logic [W-1:0]  ld_val = '0;
    logic [W-1:0]  tag_cmp = '0;
    logic [W-1:0]  lock = '0;

    logic          ready0, hit0, ev0;
    logic [W-1:0]  way0;
    logic          ready1, hit1, ev1;
    logic [W-1:0]  way1;
`ifdef L1_REPL_LOCK_EN
    logic          af0, af1;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: MRU flags per way, tree node bits per set.
    bit used0 [S][W];
    bit node1 [S][W];
    bit snap0 [W];
    bit snap1 [W];
    bit m_ready = 1'b0;
    int m_sweep = 0;
    bit p_valid = 1'b0;
    int p_idx   = 0;
    int wi0     = -1;
    int wi1     = -1;

    always #5 clk = ~clk;

    l1_repl_mgr #(.WAY_NUM(W), .SET_NUM(S), .MODE(0)) u_bit (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .idx          (idx),
        .inv_req      (inv_req),
        .ready        (ready0),
        .ld_val_vect  (ld_val),
        .tag_cmp_vect (tag_cmp),
        .hit          (hit0),
        .evict_val    (ev0),
        .way_vect     (way0)
`ifdef L1_REPL_LOCK_EN
        ,
        .lock_vect    (lock),
        .alloc_fail   (af0)
`endif
    );

    l1_repl_mgr #(.WAY_NUM(W), .SET_NUM(S), .MODE(1)) u_tree (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .idx          (idx),
        .inv_req      (inv_req),
        .ready        (ready1),
        .ld_val_vect  (ld_val),
        .tag_cmp_vect (tag_cmp),
        .hit          (hit1),
        .evict_val    (ev1),
        .way_vect     (way1)
`ifdef L1_REPL_LOCK_EN
        ,
        .lock_vect    (lock),
        .alloc_fail   (af1)
`endif
    );

    task automatic compare(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic modelLookup(input int mode, output logic e_hit, output logic e_ev,
                               output logic e_fail, output logic [W-1:0] e_way, output int wi);
        int hw, fw, vw, n, pick, c;
        hw = -1; fw = -1; vw = -1; wi = -1;
        e_hit = 1'b0; e_ev = 1'b0; e_fail = 1'b0; e_way = '0;
        if (!p_valid) return;
        for (int i = 0; i < W; i++) begin
            if (hw < 0 && ld_val[i] && tag_cmp[i]) hw = i;
            if (fw < 0 && !ld_val[i] && !lock[i]) fw = i;
        end
        if (mode == 0) begin
            for (int i = 0; i < W; i++)
                if (vw < 0 && !snap0[i] && !lock[i]) vw = i;
            for (int i = 0; i < W; i++)
                if (vw < 0 && !lock[i]) vw = i;
        end else begin
            n = 0;
            for (int l = 0; l < LW; l++) n = 2 * n + 1 + int'(snap1[n]);
            pick = n - (W - 1);
            for (int k = 0; k < W; k++) begin
                c = (pick + k) % W;
                if (vw < 0 && !lock[c]) vw = c;
            end
        end
        if (hw >= 0) begin
            e_hit = 1'b1; wi = hw;
        end else if (fw >= 0) begin
            wi = fw;
        end else if (vw >= 0) begin
            wi = vw; e_ev = 1'b1;
        end else begin
            e_fail = 1'b1;
        end
        if (wi >= 0) e_way = W'(1) << wi;
    endtask

    task automatic checkOutput();
        logic eh, ee, ef;
        logic [W-1:0] ew;
        compare("bit.ready", ready0, m_ready);
        compare("tree.ready", ready1, m_ready);
        modelLookup(0, eh, ee, ef, ew, wi0);
        compare("bit.hit", hit0, eh);
        compare("bit.evict", ev0, ee);
        compare("bit.way", way0, ew);
`ifdef L1_REPL_LOCK_EN
        compare("bit.alloc_fail", af0, ef);
`endif
        modelLookup(1, eh, ee, ef, ew, wi1);
        compare("tree.hit", hit1, eh);
        compare("tree.evict", ev1, ee);
        compare("tree.way", way1, ew);
`ifdef L1_REPL_LOCK_EN
        compare("tree.alloc_fail", af1, ef);
`endif
    endtask

    task automatic modelAdvance(input bit r, input int i, input bit inv, input bit rs);
        bit all;
        int n, d;
        bit accept;
        if (!rs && m_ready && !inv && p_valid) begin
            if (wi0 >= 0) begin
                used0[p_idx][wi0] = 1'b1;
                all = 1'b1;
                for (int k = 0; k < W; k++) all = all & used0[p_idx][k];
                if (all)
                    for (int k = 0; k < W; k++) used0[p_idx][k] = (k == wi0);
            end
            if (wi1 >= 0) begin
                n = 0;
                for (int l = 0; l < LW; l++) begin
                    d = (wi1 >> (LW - 1 - l)) & 1;
                    node1[p_idx][n] = (d == 0);
                    n = 2 * n + 1 + d;
                end
            end
        end
        accept = !rs && m_ready && r;
        if (accept)
            for (int k = 0; k < W; k++) begin
                snap0[k] = used0[i][k];
                snap1[k] = node1[i][k];
            end
        if (rs || inv) begin
            for (int s = 0; s < S; s++)
                for (int k = 0; k < W; k++) begin
                    used0[s][k] = 1'b0;
                    node1[s][k] = 1'b0;
                end
            m_ready = 1'b0;
            m_sweep = 0;
        end else if (!m_ready) begin
            m_sweep++;
            if (m_sweep == S) m_ready = 1'b1;
        end
        p_valid = accept;
        p_idx   = i;
    endtask

    // One clock: drive at the falling edge, check mid-cycle, advance the model.
    task automatic applyStimulus(input bit r, input int i, input logic [W-1:0] ld,
                                 input logic [W-1:0] tg, input logic [W-1:0] lk,
                                 input bit inv, input bit rs);
        @(negedge clk);
        rst     = rs;
        req     = r;
        idx     = IW'(i);
        ld_val  = ld;
        tag_cmp = tg;
        lock    = lk;
        inv_req = inv;
        #1;
        checkOutput();
        modelAdvance(r, i, inv, rs);
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h0, 0, 1);
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h0, 0, 1);
        for (int k = 0; k < S; k++) applyStimulus(0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        compare("ready_after_init", ready0, 1'b1);

        applyStimulus(1, 1, 4'h0, 4'h0, 4'h0, 0, 0);
        applyStimulus(0, 0, 4'b0011, 4'b0000, 4'h0, 0, 0);
        compare("alloc_invalid_way", way0, 4'b0100);
        compare("alloc_no_evict", ev0, 1'b0);

        applyStimulus(1, 5, 4'hF, 4'h0, 4'h0, 0, 0);
        applyStimulus(0, 0, 4'hF, 4'b0001, 4'h0, 0, 0);
        applyStimulus(1, 5, 4'hF, 4'h0, 4'h0, 0, 0);
        applyStimulus(0, 0, 4'hF, 4'b0010, 4'h0, 0, 0);
        applyStimulus(1, 5, 4'hF, 4'h0, 4'h0, 0, 0);
        applyStimulus(0, 0, 4'hF, 4'b0100, 4'h0, 0, 0);
        applyStimulus(1, 5, 4'hF, 4'h0, 4'h0, 0, 0);
        applyStimulus(0, 0, 4'hF, 4'b0000, 4'h0, 0, 0);
        compare("bit_victim_way3", way0, 4'b1000);
        compare("bit_victim_evict", ev0, 1'b1);
        applyStimulus(1, 5, 4'hF, 4'h0, 4'h0, 0, 0);
        applyStimulus(0, 0, 4'hF, 4'b0000, 4'h0, 0, 0);
        compare("bit_wrap_way0", way0, 4'b0001);

        applyStimulus(1, 3, 4'hF, 4'h0, 4'h0, 0, 0);
        applyStimulus(0, 0, 4'hF, 4'b0001, 4'h0, 0, 0);
        applyStimulus(1, 3, 4'hF, 4'h0, 4'h0, 0, 0);
        applyStimulus(0, 0, 4'hF, 4'b0100, 4'h0, 0, 0);
        applyStimulus(1, 3, 4'hF, 4'h0, 4'h0, 0, 0);
        applyStimulus(0, 0, 4'hF, 4'b0000, 4'h0, 0, 0);
        compare("tree_victim_way1", way1, 4'b0010);

        applyStimulus(1, 7, 4'hF, 4'h0, 4'h0, 0, 0);
        applyStimulus(1, 7, 4'hF, 4'b0001, 4'h0, 0, 0);
        applyStimulus(1, 7, 4'hF, 4'b0000, 4'h0, 0, 0);
        compare("fwd_victim_way1", way0, 4'b0010);
        applyStimulus(0, 0, 4'hF, 4'b0010, 4'h0, 1, 0);
        compare("inflight_hit_on_inv", hit0, 1'b1);
        for (int k = 0; k < S; k++) applyStimulus(0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        applyStimulus(1, 7, 4'h0, 4'h0, 4'h0, 0, 0);
        applyStimulus(0, 0, 4'hF, 4'b0000, 4'h0, 0, 0);
        compare("after_inv_way0", way0, 4'b0001);

`ifdef L1_REPL_LOCK_EN
        applyStimulus(1, 10, 4'h0, 4'h0, 4'h0, 0, 0);
        applyStimulus(1, 11, 4'hF, 4'b0000, 4'b0001, 0, 0);
        compare("lock_skip_way0", way0, 4'b0010);
        applyStimulus(0, 0, 4'hF, 4'b0000, 4'b1111, 0, 0);
        compare("lock_all_fail", af0, 1'b1);
        compare("lock_all_way", way0, 4'b0000);
`endif

        for (int n = 0; n < 800; n++) begin
            logic [W-1:0] rl, rt, rk;
            rl = ($urandom_range(0, 3) != 0) ? 4'hF : W'($urandom);
            rt = ($urandom_range(0, 2) == 0) ? 4'h0 : (W'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 7) == 0) rt = W'($urandom);
            rk = '0;
`ifdef L1_REPL_LOCK_EN
            if ($urandom_range(0, 3) == 0) rk = W'($urandom);
`endif
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7), rl, rt, rk,
                          $urandom_range(0, 249) == 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
